// File: rtl/rv32_bus_arbiter_if.sv
// Channel request/response signals plus the single downstream bus of rv32_bus_arbiter.
// master: arbiter view (drives the bus); slave: requesting channels and the bus target.
interface rv32_bus_arbiter_if #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic [CHANNELS*ADDR_WIDTH-1:0] ch_address_in;
    logic [CHANNELS-1:0]            ch_read_in;
    logic [CHANNELS-1:0]            ch_write_in;
    logic [CHANNELS*MASK_WIDTH-1:0] ch_write_mask_in;
    logic [CHANNELS*DATA_WIDTH-1:0] ch_write_value_in;
    logic [CHANNELS-1:0]            ch_ready_out;
    logic [DATA_WIDTH-1:0]          ch_read_value_out;

    logic [ADDR_WIDTH-1:0]          bus_address_out;
    logic                           bus_read_out;
    logic                           bus_write_out;
    logic [MASK_WIDTH-1:0]          bus_write_mask_out;
    logic [DATA_WIDTH-1:0]          bus_write_value_out;
    logic [DATA_WIDTH-1:0]          bus_read_value_in;
    logic                           bus_ready_in;

    modport master (
        input  ch_address_in, ch_read_in, ch_write_in, ch_write_mask_in, ch_write_value_in,
        input  bus_read_value_in, bus_ready_in,
        output ch_ready_out, ch_read_value_out,
        output bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out, bus_write_value_out
    );

    modport slave (
        output ch_address_in, ch_read_in, ch_write_in, ch_write_mask_in, ch_write_value_in,
        output bus_read_value_in, bus_ready_in,
        input  ch_ready_out, ch_read_value_out,
        input  bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out, bus_write_value_out
    );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Single-outstanding bus arbiter: IDLE grant -> ACCESS (held until bus_ready_in) -> RESPOND pulse; 3 cycles minimum.
// Grant policy: fixed lowest-index priority, or round-robin when RV32_ARB_ROUND_ROBIN_EN is defined.
module rv32_bus_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    rv32_bus_arbiter_if.master io
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int GW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MASK_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] wval_q, wval_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
`ifdef RV32_ARB_ROUND_ROBIN_EN
    logic [GW-1:0]         ptr_q, ptr_d;
`endif

    logic [CHANNELS-1:0]   req;
    logic                  grant_vld;
    logic [GW-1:0]         grant_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [MASK_WIDTH-1:0] sel_mask;
    logic [DATA_WIDTH-1:0] sel_wval;
    logic                  sel_rd;
    logic                  sel_wr;
    logic [CHANNELS-1:0]   ch_ready;

    // Descending loops: the last hit (lowest index in the pass) wins.
    always_comb begin
        req       = io.ch_read_in | io.ch_write_in;
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(ptr_q))) begin
                grant_vld = 1'b1;
                grant_idx = GW'(i);
            end
        end
        // Channels above the pointer come first in the cyclic search.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(ptr_q))) begin
                grant_vld = 1'b1;
                grant_idx = GW'(i);
            end
        end
`else
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_vld = 1'b1;
                grant_idx = GW'(i);
            end
        end
`endif
    end

    always_comb begin
        sel_addr = '0;
        sel_mask = '0;
        sel_wval = '0;
        sel_rd   = 1'b0;
        sel_wr   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (GW'(i) == grant_idx) begin
                sel_addr = io.ch_address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_mask = io.ch_write_mask_in[i*MASK_WIDTH +: MASK_WIDTH];
                sel_wval = io.ch_write_value_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_rd   = io.ch_read_in[i];
                sel_wr   = io.ch_write_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ACCESS;
            ACCESS:  if (io.bus_ready_in) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wval_d  = wval_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (grant_vld) begin
                    grant_d = grant_idx;
                    addr_d  = sel_addr;
                    mask_d  = sel_mask;
                    wval_d  = sel_wval;
                    // A combined read+write request goes out as a write.
                    wr_d    = sel_wr;
                    rd_d    = sel_rd & ~sel_wr;
`ifdef RV32_ARB_ROUND_ROBIN_EN
                    ptr_d   = grant_idx;
`endif
                end
            end
            ACCESS: begin
                if (io.bus_ready_in) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (rd_q) rdata_d = io.bus_read_value_in;
                end
            end
            default: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            wval_q  <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
            ptr_q   <= GW'(CHANNELS - 1);
`endif
        end else begin
            grant_q <= grant_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wval_q  <= wval_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef RV32_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Gated by reset so a transaction abandoned in RESPOND never pulses.
    always_comb begin
        ch_ready = '0;
        if ((state_q == RESPOND) && !reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ch_ready[i] = (GW'(i) == grant_q);
            end
        end
    end

    assign io.ch_ready_out        = ch_ready;
    assign io.ch_read_value_out   = rdata_q;
    assign io.bus_address_out     = addr_q;
    assign io.bus_read_out        = rd_q;
    assign io.bus_write_out       = wr_q;
    assign io.bus_write_mask_out  = mask_q;
    assign io.bus_write_value_out = wval_q;
endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter: 2-channel and 4-channel instances, scoreboarded ready pulses.
module tb_rv32_bus_arbiter;
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv32_bus_arbiter_if #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    rv32_bus_arbiter_if #(.CHANNELS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    rv32_bus_arbiter #(.CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset), .io(ifa)
    );
    rv32_bus_arbiter #(.CHANNELS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset), .io(ifb)
    );

    typedef struct {
        logic [7:0]  rdy;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input logic [7:0] rdy, input logic [31:0] rdata);
        exp_t e;
        e.rdy   = rdy;
        e.rdata = rdata;
        sbq.push_back(e);
    endtask

    // Waits (bounded) for the next ready pulse and compares it with the scoreboard head.
    task automatic collect(input bit use_b, input int budget, input int exp_wait, input string tag);
        int          n;
        bit          seen;
        logic [7:0]  rdy;
        logic [31:0] rv;
        exp_t        e;
        n    = 0;
        seen = 1'b0;
        rdy  = '0;
        rv   = '0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            rdy = use_b ? {4'b0, ifb.ch_ready_out} : {6'b0, ifa.ch_ready_out};
            rv  = use_b ? ifb.ch_read_value_out : ifa.ch_read_value_out;
            if (rdy != 8'h0) seen = 1'b1;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_sb_pending"}, 64'(sbq.size() != 0), 64'd1);
        if (seen && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk({tag, "_ready"}, 64'(rdy), 64'(e.rdy));
            chk({tag, "_rdata"}, 64'(rv), 64'(e.rdata));
            chk({tag, "_latency"}, 64'(n), 64'(exp_wait));
        end
    endtask

    initial begin
        reset = 1'b1;
        ifa.ch_address_in = '0;     ifa.ch_read_in = '0;       ifa.ch_write_in = '0;
        ifa.ch_write_mask_in = '0;  ifa.ch_write_value_in = '0;
        ifa.bus_read_value_in = '0; ifa.bus_ready_in = 1'b0;
        ifb.ch_address_in = '0;     ifb.ch_read_in = '0;       ifb.ch_write_in = '0;
        ifb.ch_write_mask_in = '0;  ifb.ch_write_value_in = '0;
        ifb.bus_read_value_in = '0; ifb.bus_ready_in = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_bus_read",   ifa.bus_read_out, 0);
        chk("rst_bus_write",  ifa.bus_write_out, 0);
        chk("rst_bus_addr",   ifa.bus_address_out, 0);
        chk("rst_bus_mask",   ifa.bus_write_mask_out, 0);
        chk("rst_bus_wval",   ifa.bus_write_value_out, 0);
        chk("rst_ready",      ifa.ch_ready_out, 0);
        chk("rst_rdata",      ifa.ch_read_value_out, 0);
        chk("rst_b_ready",    ifb.ch_ready_out, 0);
        reset = 1'b0;

        // Single read, ready in the first ACCESS cycle.
        ifa.ch_address_in[31:0] = 32'h100;
        ifa.ch_read_in          = 2'b01;
        ifa.bus_ready_in        = 1'b1;
        ifa.bus_read_value_in   = 32'hDEADBEEF;
        expect_txn(8'h01, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_bus_read",  ifa.bus_read_out, 1);
        chk("rd_bus_write", ifa.bus_write_out, 0);
        chk("rd_bus_addr",  ifa.bus_address_out, 32'h100);
        chk("rd_early_rdy", ifa.ch_ready_out, 0);
        collect(1'b0, 4, 1, "rd");
        chk("rd_strobe_drop", ifa.bus_read_out, 0);
        ifa.ch_read_in   = 2'b00;
        ifa.bus_ready_in = 1'b0;
        @(negedge clk);
        chk("rd_single_pulse", ifa.ch_ready_out, 0);

        // Write on ch1 with two bus wait cycles.
        ifa.ch_address_in[63:32]     = 32'h200;
        ifa.ch_write_mask_in[7:4]    = 4'b0011;
        ifa.ch_write_value_in[63:32] = 32'h1234;
        ifa.ch_write_in              = 2'b10;
        ifa.bus_read_value_in        = 32'h5555AAAA;
        expect_txn(8'h02, 32'hDEADBEEF);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("wr_bus_write", ifa.bus_write_out, 1);
            chk("wr_bus_read",  ifa.bus_read_out, 0);
            chk("wr_bus_addr",  ifa.bus_address_out, 32'h200);
            chk("wr_bus_mask",  ifa.bus_write_mask_out, 4'b0011);
            chk("wr_bus_wval",  ifa.bus_write_value_out, 32'h1234);
            chk("wr_early_rdy", ifa.ch_ready_out, 0);
            if (c == 3) ifa.bus_ready_in = 1'b1;
        end
        collect(1'b0, 4, 1, "wr");
        chk("wr_strobe_drop", ifa.bus_write_out, 0);
        ifa.ch_write_in = 2'b00;
        @(negedge clk);

        // Requests changing mid-ACCESS must not disturb the in-flight read.
        ifa.ch_address_in[31:0] = 32'h300;
        ifa.ch_read_in          = 2'b01;
        ifa.bus_ready_in        = 1'b0;
        ifa.bus_read_value_in   = 32'hCAFEF00D;
        expect_txn(8'h01, 32'hCAFEF00D);
        @(negedge clk);
        ifa.ch_read_in          = 2'b00;
        ifa.ch_write_in         = 2'b10;
        ifa.ch_address_in[31:0] = 32'h999;
        @(negedge clk);
        chk("drop_addr_hold",  ifa.bus_address_out, 32'h300);
        chk("drop_read_hold",  ifa.bus_read_out, 1);
        chk("drop_write_hold", ifa.bus_write_out, 0);
        ifa.bus_ready_in = 1'b1;
        collect(1'b0, 4, 1, "drop");
        ifa.ch_write_in = 2'b00;
        @(negedge clk);

        // Read and write both set: issued as a write, read data untouched.
        ifa.ch_address_in[31:0] = 32'h40;
        ifa.ch_read_in          = 2'b01;
        ifa.ch_write_in         = 2'b01;
        ifa.bus_read_value_in   = 32'h0BAD0BAD;
        expect_txn(8'h01, 32'hCAFEF00D);
        @(negedge clk);
        chk("rw_bus_write", ifa.bus_write_out, 1);
        chk("rw_bus_read",  ifa.bus_read_out, 0);
        chk("rw_bus_addr",  ifa.bus_address_out, 32'h40);
        collect(1'b0, 4, 1, "rw");
        ifa.ch_read_in  = 2'b00;
        ifa.ch_write_in = 2'b00;
        @(negedge clk);
        chk("rw_single_pulse", ifa.ch_ready_out, 0);

        // Reset during ACCESS abandons the transaction.
        ifa.ch_address_in[63:32] = 32'h500;
        ifa.ch_read_in           = 2'b10;
        ifa.bus_ready_in         = 1'b0;
        @(negedge clk);
        chk("rstacc_read_before", ifa.bus_read_out, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstacc_read_after", ifa.bus_read_out, 0);
        chk("rstacc_ready",      ifa.ch_ready_out, 0);
        chk("rstacc_rdata",      ifa.ch_read_value_out, 0);
        reset          = 1'b0;
        ifa.ch_read_in = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstacc_no_pulse", ifa.ch_ready_out, 0);
        end

        // Both channels request continuously; first grant also shows IDLE after reset.
        ifa.ch_address_in     = {32'h700, 32'h600};
        ifa.ch_read_in        = 2'b11;
        ifa.bus_ready_in      = 1'b1;
        ifa.bus_read_value_in = 32'h600D0001;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        expect_txn(8'h01, 32'h600D0001);
        expect_txn(8'h02, 32'h600D0001);
        expect_txn(8'h01, 32'h600D0001);
        expect_txn(8'h02, 32'h600D0001);
`else
        for (int k = 0; k < 4; k++) expect_txn(8'h01, 32'h600D0001);
`endif
        collect(1'b0, 5, 2, "both_0");
        collect(1'b0, 5, 3, "both_1");
        collect(1'b0, 5, 3, "both_2");
        collect(1'b0, 5, 3, "both_3");
        ifa.ch_read_in = 2'b00;
        @(negedge clk);

        // Four channels, requests on ch1 and ch3 from the reset pointer.
        ifb.ch_read_in        = 4'b1010;
        ifb.bus_ready_in      = 1'b1;
        ifb.bus_read_value_in = 32'h0000B0B0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        expect_txn(8'h02, 32'h0000B0B0);
        expect_txn(8'h08, 32'h0000B0B0);
        expect_txn(8'h02, 32'h0000B0B0);
`else
        for (int k = 0; k < 3; k++) expect_txn(8'h02, 32'h0000B0B0);
`endif
        collect(1'b1, 5, 2, "four_0");
        collect(1'b1, 5, 3, "four_1");
        collect(1'b1, 5, 3, "four_2");
        ifb.ch_read_in = 4'b0000;
        @(negedge clk);

        chk("sb_drained", 64'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
